// File: rtl/ana_pad_pkg.sv
// Shared types and helpers for the analog pad scan controller.
// Holds the FSM state encoding and the channel search used by the priority encoder.
package ana_pad_pkg;

  localparam int MAX_CH   = 16;
  localparam int CH_IDX_W = $clog2(MAX_CH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BBM,
    S_SETTLE,
    S_CONV,
    S_OUT
  } state_t;

  // Returns {found, index} of the lowest set bit strictly above cur, or from bit 0 when first=1.
  function automatic logic [CH_IDX_W:0] next_ch(input logic [MAX_CH-1:0] mask,
                                                input logic [CH_IDX_W-1:0] cur,
                                                input logic first);
    logic [CH_IDX_W:0] r;
    r = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (first || (i > int'(cur)))) r = {1'b1, CH_IDX_W'(i)};
    end
    return r;
  endfunction

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ana_pad_scan_ctrl_if.sv
// Bundle of the control, analog-mux, ADC and result-stream signals of the scan controller.
// Result stream: a beat transfers on a rising clk edge where res_valid & res_ready; once
// res_valid rises, res_data/res_ch/res_err hold steady and res_valid stays high until that beat.
interface ana_pad_scan_ctrl_if #(
  parameter int N_CH = 8,
  parameter int DW   = 10
);
  localparam int CHW = $clog2(N_CH);

  logic            start;
  logic            cont;
  logic [N_CH-1:0] ch_en;
  logic [N_CH-1:0] sel;
  logic            adc_start;
  logic            adc_done;
  logic [DW-1:0]   adc_data;
  logic            res_valid;
  logic            res_ready;
  logic [DW-1:0]   res_data;
  logic [CHW-1:0]  res_ch;
  logic            res_err;
  logic            busy;

  modport master (
    input  start, cont, ch_en, adc_done, adc_data, res_ready,
    output sel, adc_start, res_valid, res_data, res_ch, res_err, busy
  );

  modport slave (
    output start, cont, ch_en, adc_done, adc_data, res_ready,
    input  sel, adc_start, res_valid, res_data, res_ch, res_err, busy
  );
endinterface

// File: rtl/ana_pad_prio_enc.sv
// Priority encoder: lowest set mask bit above cur (or from bit 0 when first=1), with a found flag.
module ana_pad_prio_enc
  import ana_pad_pkg::*;
#(
  parameter int N = 8,
  localparam int CW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [CW-1:0] cur,
  input  logic          first,
  output logic [CW-1:0] idx,
  output logic          found
);
  logic [MAX_CH-1:0]   m;
  logic [CH_IDX_W:0]   r;

  always_comb begin
    m          = '0;
    m[N-1:0]   = mask;
    r          = next_ch(m, CH_IDX_W'(cur), first);
    found      = r[CH_IDX_W];
    idx        = r[CW-1:0];
  end
endmodule

// File: rtl/ana_pad_scan_ctrl.sv
// Scan sequencer for the analog pad mux: break-before-make, settle, one ADC conversion per
// enabled channel, and a tagged result stream. All outputs are registered.
module ana_pad_scan_ctrl
  import ana_pad_pkg::*;
#(
  parameter int N_CH    = 8,
  parameter int DW      = 10,
  parameter int BBM     = 2,
  parameter int SETTLE  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  ana_pad_scan_ctrl_if.master  bus,
  output state_t               dbg_state
);
  localparam int CHW   = $clog2(N_CH);
  localparam int CNT_W = cnt_width(BBM, SETTLE, TIMEOUT);

  state_t          state;
  logic [N_CH-1:0] mask;
  logic [CHW-1:0]  ch;
  logic [CNT_W-1:0] cnt;

  logic [CHW-1:0]  nxt_idx, fst_idx;
  logic            nxt_found, fst_found;

  // Next channel within the latched mask, and lowest channel of the live enable mask.
  ana_pad_prio_enc #(.N(N_CH)) u_nxt (
    .mask(mask), .cur(ch), .first(1'b0), .idx(nxt_idx), .found(nxt_found)
  );
  ana_pad_prio_enc #(.N(N_CH)) u_fst (
    .mask(bus.ch_en), .cur(ch), .first(1'b1), .idx(fst_idx), .found(fst_found)
  );

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      mask          <= '0;
      ch            <= '0;
      cnt           <= '0;
      bus.sel       <= '0;
      bus.adc_start <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_ch    <= '0;
      bus.res_err   <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.adc_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start && fst_found) begin
            mask     <= bus.ch_en;
            ch       <= fst_idx;
            cnt      <= CNT_W'(BBM - 1);
            bus.busy <= 1'b1;
            state    <= S_BBM;
          end
        end
        S_BBM: begin
          if (cnt == '0) begin
            bus.sel <= {{(N_CH-1){1'b0}}, 1'b1} << ch;
            cnt     <= CNT_W'(SETTLE - 1);
            state   <= S_SETTLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_SETTLE: begin
          if (cnt == '0) begin
            bus.adc_start <= 1'b1;
            cnt           <= CNT_W'(TIMEOUT - 1);
            state         <= S_CONV;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_CONV: begin
          // adc_done is checked first so it wins over a coincident timeout.
          if (bus.adc_done) begin
            bus.res_data  <= bus.adc_data;
            bus.res_err   <= 1'b0;
            bus.res_ch    <= ch;
            bus.res_valid <= 1'b1;
            state         <= S_OUT;
          end else if (cnt == '0) begin
            bus.res_data  <= '0;
            bus.res_err   <= 1'b1;
            bus.res_ch    <= ch;
            bus.res_valid <= 1'b1;
            state         <= S_OUT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_OUT: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.sel       <= '0;
            if (nxt_found) begin
              ch    <= nxt_idx;
              cnt   <= CNT_W'(BBM - 1);
              state <= S_BBM;
            end else if (bus.cont && fst_found) begin
              mask  <= bus.ch_en;
              ch    <= fst_idx;
              cnt   <= CNT_W'(BBM - 1);
              state <= S_BBM;
            end else begin
              bus.busy <= 1'b0;
              state    <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ana_pad_scan_ctrl.sv
// Self-checking bench for ana_pad_scan_ctrl: ADC responder, timing monitor and result scoreboard.
module tb_ana_pad_scan_ctrl;
  import ana_pad_pkg::*;

  localparam int N_CH    = 8;
  localparam int DW      = 10;
  localparam int BBM     = 2;
  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 255;
  localparam int CHW     = $clog2(N_CH);
  localparam int EW      = 1 + CHW + DW;
  localparam int LIM     = 2000;

  logic   clk, rst;
  state_t dbg_state;
  int     checks, errors, cyc;

  ana_pad_scan_ctrl_if #(.N_CH(N_CH), .DW(DW)) bus ();

  ana_pad_scan_ctrl #(
    .N_CH(N_CH), .DW(DW), .BBM(BBM), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model state: channel order from the latched masks, results in order of conversion
  logic [EW-1:0]  exp_q[$];
  int             lat_q[$];
  logic [CHW-1:0] ch_q[$];

  logic           resp_en, fixed_en, stray_en;
  logic [DW-1:0]  fixed_data;
  int             fixed_d, dmax;

  logic [N_CH-1:0] prev_sel;
  int              sel_run, zero_run, start_cyc, pend;
  bit              had_sel, prev_start, prev_valid, pend_act;
  logic [DW-1:0]   pend_data;

  // ADC responder and cycle monitor, evaluated away from the active edge
  always @(negedge clk) begin
    logic [CHW-1:0] c;
    logic [DW-1:0]  d_data;
    int             d, l;
    cyc++;
    bus.adc_done = 1'b0;
    if (rst) begin
      pend_act = 0; had_sel = 0; zero_run = 0; sel_run = 0;
      prev_sel = '0; prev_start = 0; prev_valid = 0;
    end else begin
      checks++;
      if ((bus.sel & (bus.sel - 1'b1)) != '0) begin
        errors++;
        $display("FAIL sel_onehot: sel=%b required one-hot or zero", bus.sel);
      end
      if (bus.sel == '0) begin
        zero_run++;
        sel_run = 0;
      end else begin
        if (bus.sel != prev_sel) begin
          if (had_sel) begin
            checks++;
            if (zero_run !== BBM) begin
              errors++;
              $display("FAIL bbm_gap: got %0d all-off cycles required %0d", zero_run, BBM);
            end
          end
          sel_run = 1;
          had_sel = 1;
          if (stray_en) begin
            bus.adc_done = 1'b1;
            bus.adc_data = '1;
          end
        end else begin
          sel_run++;
        end
        zero_run = 0;
      end
      if (bus.adc_start) begin
        checks++;
        if (sel_run !== SETTLE + 1 || prev_start) begin
          errors++;
          $display("FAIL settle: select held %0d cycles (prev start %0d) required %0d", sel_run, prev_start, SETTLE + 1);
        end
        start_cyc = cyc;
        checks++;
        if (ch_q.size() == 0) begin
          errors++;
          $display("FAIL adc_start_unexpected: got adc_start with no channel pending, required none");
        end else begin
          c = ch_q.pop_front();
          if (resp_en) begin
            d      = fixed_en ? fixed_d : $urandom_range(0, dmax);
            d_data = fixed_en ? fixed_data : DW'($urandom);
            exp_q.push_back({1'b0, c, d_data});
            lat_q.push_back(d + 1);
            pend = d; pend_act = 1; pend_data = d_data;
          end else begin
            exp_q.push_back({1'b1, c, {DW{1'b0}}});
            lat_q.push_back(TIMEOUT);
          end
        end
      end
      if (pend_act) begin
        if (pend == 0) begin
          bus.adc_done = 1'b1;
          bus.adc_data = pend_data;
          pend_act = 0;
        end else begin
          pend--;
        end
      end
      if (bus.res_valid && !prev_valid) begin
        checks++;
        if (lat_q.size() == 0) begin
          errors++;
          $display("FAIL res_unexpected: res_valid rose with no conversion pending");
        end else begin
          l = lat_q.pop_front();
          if (cyc - start_cyc !== l) begin
            errors++;
            $display("FAIL latency: got %0d cycles from adc_start to res_valid required %0d", cyc - start_cyc, l);
          end
        end
      end
      if (!bus.busy) had_sel = 0;
      prev_sel   = bus.sel;
      prev_start = bus.adc_start;
      prev_valid = bus.res_valid;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_chs(input logic [N_CH-1:0] m);
    for (int i = 0; i < N_CH; i++) if (m[i]) ch_q.push_back(CHW'(i));
  endtask

  task automatic pulse_start(input logic [N_CH-1:0] m);
    bus.ch_en = m;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic collect(input int n, input int min_stall, input int max_stall);
    logic [EW-1:0]   got, exp;
    logic [N_CH-1:0] s_sel;
    int t, stall;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!bus.res_valid && t < LIM) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (!bus.res_valid) begin
        errors++;
        $display("FAIL res_wait: res_valid=0 after %0d cycles required 1", LIM);
        return;
      end
      got   = {bus.res_err, bus.res_ch, bus.res_data};
      s_sel = bus.sel;
      stall = $urandom_range(min_stall, max_stall);
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        checks++;
        if (!bus.res_valid || {bus.res_err, bus.res_ch, bus.res_data} !== got || bus.sel !== s_sel) begin
          errors++;
          $display("FAIL hold: valid=%b res=%h sel=%b required valid=1 res=%h sel=%b",
                   bus.res_valid, {bus.res_err, bus.res_ch, bus.res_data}, bus.sel, got, s_sel);
        end
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result_extra: got %h with no expected result", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL result: got err/ch/data=%h required %h", got, exp);
        end
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (bus.busy && t < LIM) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.sel !== '0) begin
      errors++;
      $display("FAIL idle: busy=%b sel=%b required busy=0 sel=0", bus.busy, bus.sel);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (bus.sel !== '0 || bus.adc_start !== 1'b0 || bus.res_valid !== 1'b0 || bus.res_data !== '0 ||
        bus.res_ch !== '0 || bus.res_err !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: sel=%b start=%b valid=%b data=%h ch=%0d err=%b busy=%b required all zero", tag,
               bus.sel, bus.adc_start, bus.res_valid, bus.res_data, bus.res_ch, bus.res_err, bus.busy);
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    check_reset_values("reset_values");
    rst = 1'b0;
    tick(2);
    check_reset_values("idle_after_reset");
  endtask

  task automatic test_basic();
    int t;
    fixed_en = 1; fixed_d = 3; fixed_data = 10'h155;
    push_chs(8'b0000_0101);
    pulse_start(8'b0000_0101);
    t = 0;
    while (bus.sel == '0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t !== BBM || bus.sel !== 8'h01) begin
      errors++;
      $display("FAIL first_select: got %0d off cycles sel=%h required %0d sel=01", t, bus.sel, BBM);
    end
    collect(2, 0, 0);
    wait_idle();
    fixed_en = 0;
  endtask

  task automatic test_backpressure();
    logic [N_CH-1:0] m;
    m = N_CH'(1) << $urandom_range(0, N_CH - 1);
    push_chs(m);
    pulse_start(m);
    collect(1, 50, 50);
    wait_idle();
  endtask

  task automatic test_timeout();
    resp_en = 0;
    push_chs(8'b0001_0010);
    pulse_start(8'b0001_0010);
    collect(2, 0, 3);
    wait_idle();
    resp_en = 1;
  endtask

  task automatic test_cont();
    repeat (3) push_chs(8'h80);
    bus.cont = 1'b1;
    pulse_start(8'h80);
    collect(2, 0, 5);
    bus.cont = 1'b0;
    collect(1, 0, 0);
    wait_idle();
  endtask

  task automatic test_rst_mid();
    logic [N_CH-1:0] m;
    int t;
    push_chs(8'h08);
    pulse_start(8'h08);
    t = 0;
    while (bus.sel !== 8'h08 && t < 50) begin
      @(negedge clk);
      t++;
    end
    tick(3);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("reset_mid_scan");
    rst = 1'b0;
    ch_q.delete();
    tick(2);
    m = N_CH'($urandom_range(1, 255));
    push_chs(m);
    pulse_start(m);
    collect($countones(m), 0, 4);
    wait_idle();
  endtask

  task automatic test_sanity();
    logic [N_CH-1:0] m;
    pulse_start('0);
    tick(10);
    checks++;
    if (bus.busy !== 1'b0 || bus.sel !== '0) begin
      errors++;
      $display("FAIL empty_start: busy=%b sel=%b required busy=0 sel=0", bus.busy, bus.sel);
    end
    stray_en = 1;
    m = N_CH'($urandom_range(1, 255));
    push_chs(m);
    pulse_start(m);
    tick(4);
    pulse_start(~m | 8'h01);
    collect($countones(m), 0, 2);
    stray_en = 0;
    wait_idle();
  endtask

  task automatic test_random();
    logic [N_CH-1:0] m;
    for (int i = 0; i < 4; i++) begin
      m    = N_CH'($urandom_range(1, 255));
      dmax = $urandom_range(0, 20);
      push_chs(m);
      pulse_start(m);
      collect($countones(m), 0, 6);
      wait_idle();
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.cont = 1'b0; bus.ch_en = '0; bus.res_ready = 1'b0;
    bus.adc_data = '0;
    resp_en = 1; fixed_en = 0; stray_en = 0; fixed_data = '0; fixed_d = 0; dmax = 8;
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_cont();
    test_rst_mid();
    test_sanity();
    test_random();
    tick(5);
    checks++;
    if (exp_q.size() != 0 || ch_q.size() != 0) begin
      errors++;
      $display("FAIL leftovers: %0d results and %0d channels outstanding required 0", exp_q.size(), ch_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
